uart_master_apb: RTL and testbench

APB slave register block for the UART. Decodes APB accesses into a seven-register map and drives the UART configuration (baud divisor, parity, stop bits). Pushes transmit bytes toward the TX FIFO, pops received bytes from the RX FIFO, and aggregates latched line errors into one maskable interrupt. Sits between the system APB bus and the UART TX/RX engines and FIFOs.

---
 rtl/uart_master_apb.sv | 95 +++++++++
 tb/tb_uart_master_apb.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_master_apb.sv
// uart_master_apb: APB register block for UART config, TX/RX FIFO access and error interrupt.
module uart_master_apb (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] PADDR,
    input  logic        PSELx,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic        PREADY,
    output logic [31:0] PRDATA,
    output logic        PSLVERR,
    output logic [7:0]  TX_DATA,
    input  logic [7:0]  RX_DATA,
    output logic [31:0] BAUD,
    output logic [1:0]  PARITY_MODE,
    output logic [1:0]  STOP_BITS,
    input  logic        TX_DONE,
    input  logic        TX_NOTFULL,
    input  logic        RX_NOTFULL,
    input  logic        RX_NOTEMPTY,
    input  logic        PARITY_ERROR,
    input  logic        FRAME_ERROR,
    input  logic        OVERRUN_ERROR,
    input  logic        BREAK_ERROR,
    output logic        interrupt,
    output logic        tx_fifo_write_en,
    output logic        rx_fifo_read_en,
    output logic [31:0] probe_tx_reg,
    output logic [1:0]  probe_tx_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;
    state_t      state, state_next;
    logic [31:0] tx_q, baud_q, wmask, rd_mux;
    logic [3:0]  ctrl, int_en, err_q, err_in, clr;
    logic        sel_tx, sel_rx, sel_baud, sel_stat, sel_ctrl, sel_clr, sel_ie;
    logic        err, ok, wr, rd;
    always_comb begin
        state_next = IDLE;
        state_next = PSELx ? (PENABLE ? ACCESS : SETUP) : IDLE;
    end
    // Bus is held off while in reset so a mid-transfer reset commits nothing.
    assign PREADY   = PSELx & PENABLE & ~resetn;
    assign sel_tx   = PADDR == 32'h00;
    assign sel_rx   = PADDR == 32'h04;
    assign sel_baud = PADDR == 32'h08;
    assign sel_stat = PADDR == 32'h0C;
    assign sel_ctrl = PADDR == 32'h10;
    assign sel_clr  = PADDR == 32'h14;
    assign sel_ie   = PADDR == 32'h18;
    assign err = ~(sel_tx | sel_rx | sel_baud | sel_stat | sel_ctrl | sel_clr | sel_ie)
               | (PWRITE & (sel_rx | sel_stat | (sel_tx & ~TX_NOTFULL)))
               | (~PWRITE & (sel_tx | sel_clr | (sel_rx & ~RX_NOTEMPTY)));
    assign ok      = PREADY & ~err;
    assign wr      = ok & PWRITE;
    assign rd      = ok & ~PWRITE;
    assign PSLVERR = PREADY & err;
    assign wmask   = {{8{PSTRB[3]}}, {8{PSTRB[2]}}, {8{PSTRB[1]}}, {8{PSTRB[0]}}};
    assign rd_mux  = sel_rx   ? {24'b0, RX_DATA} :
                     sel_baud ? baud_q :
                     sel_stat ? {24'b0, err_q, RX_NOTEMPTY, RX_NOTFULL, TX_NOTFULL, TX_DONE} :
                     sel_ctrl ? {28'b0, ctrl} :
                     sel_ie   ? {24'b0, int_en, 4'b0} : 32'b0;
    assign PRDATA           = rd ? rd_mux : 32'b0;
    assign tx_fifo_write_en = wr & sel_tx & PSTRB[0];
    assign rx_fifo_read_en  = rd & sel_rx;
    assign err_in = {BREAK_ERROR, FRAME_ERROR, OVERRUN_ERROR, PARITY_ERROR};
    assign clr    = (wr & sel_clr & PSTRB[0]) ? PWDATA[7:4] : 4'b0;
    assign TX_DATA        = tx_q[7:0];
    assign probe_tx_reg   = tx_q;
    assign BAUD           = baud_q;
    assign PARITY_MODE    = ctrl[1:0];
    assign STOP_BITS      = ctrl[3:2];
    assign probe_tx_state = state;
    always_ff @(posedge clk) begin
        if (resetn) begin
            state     <= IDLE;
            tx_q      <= '0;
            baud_q    <= '0;
            ctrl      <= '0;
            int_en    <= '0;
            err_q     <= '0;
            interrupt <= 1'b0;
        end else begin
            state <= state_next;
            if (wr & sel_tx) tx_q <= (tx_q & ~wmask) | (PWDATA & wmask);
            if (wr & sel_baud) baud_q <= (baud_q & ~wmask) | (PWDATA & wmask);
            if (wr & sel_ctrl & PSTRB[0]) ctrl <= PWDATA[3:0];
            if (wr & sel_ie & PSTRB[0]) int_en <= PWDATA[7:4];
            err_q     <= err_in | (err_q & ~clr);
            interrupt <= |(err_q & int_en);
        end
    end
endmodule

// File: tb/tb_uart_master_apb.sv
// tb_uart_master_apb: directed APB transfers with a queue of expected bus responses.
module tb_uart_master_apb;
    logic        clk = 1'b0, resetn;
    logic [31:0] PADDR, PWDATA, PRDATA, BAUD, probe_tx_reg;
    logic        PSELx, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [3:0]  PSTRB;
    logic [7:0]  TX_DATA, RX_DATA;
    logic [1:0]  PARITY_MODE, STOP_BITS, probe_tx_state;
    logic        TX_DONE, TX_NOTFULL, RX_NOTFULL, RX_NOTEMPTY;
    logic        PARITY_ERROR, FRAME_ERROR, OVERRUN_ERROR, BREAK_ERROR;
    logic        interrupt, tx_fifo_write_en, rx_fifo_read_en;
    int          errors = 0, checks = 0;
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tx;
        logic        rx;
    } exp_t;
    exp_t sb[$];
    uart_master_apb dut (
        .clk(clk), .resetn(resetn), .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA),
        .PSLVERR(PSLVERR), .TX_DATA(TX_DATA), .RX_DATA(RX_DATA), .BAUD(BAUD),
        .PARITY_MODE(PARITY_MODE), .STOP_BITS(STOP_BITS), .TX_DONE(TX_DONE),
        .TX_NOTFULL(TX_NOTFULL), .RX_NOTFULL(RX_NOTFULL), .RX_NOTEMPTY(RX_NOTEMPTY),
        .PARITY_ERROR(PARITY_ERROR), .FRAME_ERROR(FRAME_ERROR), .OVERRUN_ERROR(OVERRUN_ERROR),
        .BREAK_ERROR(BREAK_ERROR), .interrupt(interrupt), .tx_fifo_write_en(tx_fifo_write_en),
        .rx_fifo_read_en(rx_fifo_read_en), .probe_tx_reg(probe_tx_reg),
        .probe_tx_state(probe_tx_state)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic apb(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] er, input logic ee,
                       input logic et, input logic ex, input string tag);
        exp_t e;
        sb.push_back('{er, ee, et, ex});
        @(posedge clk); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d; PSTRB = s;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(negedge clk);
        check({tag, " pready"}, 32'(PREADY), 32'd1);
        e = sb.pop_front();
        check({tag, " prdata"}, PRDATA, e.rdata);
        check({tag, " pslverr"}, 32'(PSLVERR), 32'(e.err));
        check({tag, " tx_en"}, 32'(tx_fifo_write_en), 32'(e.tx));
        check({tag, " rx_en"}, 32'(rx_fifo_read_en), 32'(e.rx));
        @(posedge clk); #1;
        PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 4'h0;
    endtask
    initial begin
        resetn = 1'b1; PADDR = 32'h8; PSELx = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1;
        PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF; RX_DATA = 8'h0;
        TX_DONE = 0; TX_NOTFULL = 0; RX_NOTFULL = 0; RX_NOTEMPTY = 0;
        PARITY_ERROR = 0; FRAME_ERROR = 0; OVERRUN_ERROR = 0; BREAK_ERROR = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst pready", 32'(PREADY), 32'd0);
        check("rst pslverr", 32'(PSLVERR), 32'd0);
        check("rst prdata", PRDATA, 32'd0);
        check("rst tx_en", 32'(tx_fifo_write_en), 32'd0);
        check("rst state", 32'(probe_tx_state), 32'd0);
        PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        check("rst baud", BAUD, 32'd0);
        check("rst irq", 32'(interrupt), 32'd0);
        apb(1, 32'h08, 32'h1, 4'h1, 32'h0, 0, 0, 0, "wr baud");
        check("baud", BAUD, 32'h1);
        check("state access", 32'(probe_tx_state), 32'd2);
        @(posedge clk); #1;
        check("state idle", 32'(probe_tx_state), 32'd0);
        apb(0, 32'h08, 32'h0, 4'h0, 32'h1, 0, 0, 0, "rd baud");
        resetn = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b0;
        check("baud after rst", BAUD, 32'd0);
        TX_NOTFULL = 1'b1;
        apb(1, 32'h00, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 1, 0, "wr tx");
        check("tx reg", probe_tx_reg, 32'hDEAD_BEEF);
        check("tx data", 32'(TX_DATA), 32'hEF);
        apb(1, 32'h00, 32'h1111_DCBA, 4'h3, 32'h0, 0, 1, 0, "wr tx strb");
        check("tx reg strb", probe_tx_reg, 32'hDEAD_DCBA);
        TX_DONE = 1; RX_NOTEMPTY = 1; RX_NOTFULL = 1; FRAME_ERROR = 1;
        @(posedge clk); #1;
        apb(0, 32'h0C, 32'h0, 4'h0, 32'h4F, 0, 0, 0, "rd status");
        apb(1, 32'h18, 32'h40, 4'h1, 32'h0, 0, 0, 0, "wr int_en");
        @(posedge clk); #1;
        check("irq set", 32'(interrupt), 32'd1);
        apb(0, 32'h18, 32'h0, 4'h0, 32'h40, 0, 0, 0, "rd int_en");
        FRAME_ERROR = 0;
        apb(1, 32'h14, 32'h40, 4'h1, 32'h0, 0, 0, 0, "clr frame");
        @(posedge clk); #1;
        check("irq clr", 32'(interrupt), 32'd0);
        apb(0, 32'h0C, 32'h0, 4'h0, 32'h0F, 0, 0, 0, "rd status clr");
        RX_DATA = 8'h0A;
        apb(0, 32'h04, 32'h0, 4'h0, 32'h0A, 0, 0, 1, "rd rx");
        RX_NOTEMPTY = 0;
        apb(0, 32'h04, 32'h0, 4'h0, 32'h0, 1, 0, 0, "rd rx empty");
        apb(1, 32'h08, 32'h1234_5678, 4'hF, 32'h0, 0, 0, 0, "wr baud full");
        apb(1, 32'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, 0, 0, "wr status");
        apb(0, 32'h14, 32'h0, 4'h0, 32'h0, 1, 0, 0, "rd clr");
        apb(0, 32'h20, 32'h0, 4'h0, 32'h0, 1, 0, 0, "rd 0x20");
        apb(1, 32'h20, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, 0, 0, "wr 0x20");
        apb(1, 32'h09, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, 0, 0, "wr unaligned");
        apb(0, 32'h0A, 32'h0, 4'h0, 32'h0, 1, 0, 0, "rd unaligned");
        check("baud kept", BAUD, 32'h1234_5678);
        TX_NOTFULL = 0;
        apb(1, 32'h00, 32'h55, 4'hF, 32'h0, 1, 0, 0, "wr tx full");
        check("tx reg kept", probe_tx_reg, 32'hDEAD_DCBA);
        TX_NOTFULL = 1;
        apb(1, 32'h10, 32'hFFFF_FFFF, 4'h1, 32'h0, 0, 0, 0, "wr ctrl");
        check("parity", 32'(PARITY_MODE), 32'd3);
        check("stop", 32'(STOP_BITS), 32'd3);
        apb(0, 32'h10, 32'h0, 4'h0, 32'hF, 0, 0, 0, "rd ctrl");
        PARITY_ERROR = 1;
        @(posedge clk); #1;
        apb(1, 32'h14, 32'h10, 4'h1, 32'h0, 0, 0, 0, "clr vs set");
        apb(0, 32'h0C, 32'h0, 4'h0, 32'h17, 0, 0, 0, "rd status set");
        PARITY_ERROR = 0;
        apb(1, 32'h14, 32'h10, 4'h0, 32'h0, 0, 0, 0, "clr no strb");
        apb(0, 32'h0C, 32'h0, 4'h0, 32'h17, 0, 0, 0, "rd status kept");
        apb(1, 32'h14, 32'h10, 4'h1, 32'h0, 0, 0, 0, "clr parity");
        apb(0, 32'h0C, 32'h0, 4'h0, 32'h07, 0, 0, 0, "rd status final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
